ring_renderer: RTL and testbench

RING_RENDERER -- requirements
Module: ring_renderer

---
 rtl/ring_pkg.sv | 30 +++
 rtl/ring_hit.sv | 64 ++++++
 rtl/ring_renderer.sv | 124 ++++++++++++
 tb/tb_ring_renderer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ring_pkg : shared ring configuration record, pipeline depth, width helpers |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package ring_pkg;

  localparam int PIPE_LAT     = 3;
  localparam int RING_COORD_W = 10;
  localparam int RING_COLOR_W = 12;

  typedef struct packed {
    logic [RING_COORD_W-1:0] cx;
    logic [RING_COORD_W-1:0] cy;
    logic [RING_COORD_W-1:0] r_in;
    logic [RING_COORD_W-1:0] r_out;
    logic [RING_COLOR_W-1:0] color;
  } ring_cfg_t;

  // Signed deltas are COORD_W+1 bits, so the sum of two squares needs 2*COORD_W+2.
  function automatic int d2_width(input int coord_w);
    return 2 * coord_w + 2;
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_hit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ring_hit : per-ring delta/square pipeline (S1, S2) and annulus hit test     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ring_hit
  import ring_pkg::*;
#(
  parameter int COORD_W = RING_COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] r_in,
  input  logic [COORD_W-1:0] r_out,
  output logic               hit
);

  localparam int c_D2_W = d2_width(COORD_W);

  logic signed [COORD_W:0]  r_dx;
  logic signed [COORD_W:0]  r_dy;
  logic        [c_D2_W-1:0] r_dx2;
  logic        [c_D2_W-1:0] r_dy2;

  logic signed [c_D2_W-1:0] w_dx_ext;
  logic signed [c_D2_W-1:0] w_dy_ext;
  logic        [c_D2_W-1:0] w_rin_ext;
  logic        [c_D2_W-1:0] w_rout_ext;
  logic        [c_D2_W-1:0] w_d2;
  logic        [c_D2_W-1:0] w_rin2;
  logic        [c_D2_W-1:0] w_rout2;

  assign w_dx_ext = c_D2_W'(r_dx);
  assign w_dy_ext = c_D2_W'(r_dy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dx  <= '0;
      r_dy  <= '0;
      r_dx2 <= '0;
      r_dy2 <= '0;
    end else begin
      r_dx  <= $signed({1'b0, x}) - $signed({1'b0, cx});
      r_dy  <= $signed({1'b0, y}) - $signed({1'b0, cy});
      r_dx2 <= w_dx_ext * w_dx_ext;
      r_dy2 <= w_dy_ext * w_dy_ext;
    end
  end

  // Radii are squared at full width so large rings never wrap.
  assign w_rin_ext  = c_D2_W'(r_in);
  assign w_rout_ext = c_D2_W'(r_out);
  assign w_rin2     = w_rin_ext * w_rin_ext;
  assign w_rout2    = w_rout_ext * w_rout_ext;
  assign w_d2       = r_dx2 + r_dy2;

  assign hit = (r_out > r_in) && (w_d2 >= w_rin2) && (w_d2 < w_rout2);

endmodule
`default_nettype wire

// File: rtl/ring_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ring_renderer : 3-stage ring overlay with double-buffered ring config;      |
// |                 define RING_CHECKER_EN for a checkerboard background.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ring_renderer
  import ring_pkg::*;
#(
  parameter int NUM_RINGS = 4,
  parameter int COORD_W   = RING_COORD_W,
  parameter int COLOR_W   = RING_COLOR_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COORD_W-1:0]              x,
  input  logic [COORD_W-1:0]              y,
  input  logic                            video_on_in,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic [COLOR_W-1:0]              bg_color,
  input  logic                            cfg_we,
  input  logic [sel_width(NUM_RINGS)-1:0] cfg_sel,
  input  logic [COORD_W-1:0]              cfg_cx,
  input  logic [COORD_W-1:0]              cfg_cy,
  input  logic [COORD_W-1:0]              cfg_r_in,
  input  logic [COORD_W-1:0]              cfg_r_out,
  input  logic [COLOR_W-1:0]              cfg_color,
  output logic [COLOR_W-1:0]              rgb,
  output logic                            hsync,
  output logic                            vsync,
  output logic                            video_on
);

  localparam int c_SEL_W = sel_width(NUM_RINGS);

  ring_cfg_t r_stage  [NUM_RINGS];
  ring_cfg_t r_active [NUM_RINGS];
  ring_cfg_t w_wr_cfg;
  logic      r_vsync_prev;
  logic      r_copy;

  logic [2:0]           r_tim_s1;
  logic [2:0]           r_tim_s2;
  logic [NUM_RINGS-1:0] w_hit;
  logic [COLOR_W-1:0]   w_nohit;
  logic [COLOR_W-1:0]   w_pix;

  assign w_wr_cfg = '{cx: cfg_cx, cy: cfg_cy, r_in: cfg_r_in, r_out: cfg_r_out, color: cfg_color};

  // Copy happens one cycle after the vsync rise; a write in that cycle stays staged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vsync_prev <= 1'b0;
      r_copy       <= 1'b0;
      for (int k = 0; k < NUM_RINGS; k++) begin
        r_stage[k]  <= '0;
        r_active[k] <= '0;
      end
    end else begin
      r_vsync_prev <= vsync_in;
      r_copy       <= vsync_in & ~r_vsync_prev;
      for (int k = 0; k < NUM_RINGS; k++) begin
        if (cfg_we && (cfg_sel == c_SEL_W'(k))) r_stage[k] <= w_wr_cfg;
        if (r_copy) r_active[k] <= r_stage[k];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_RINGS; g++) begin : g_ring
      ring_hit #(.COORD_W(COORD_W)) u_hit (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y),
        .cx    (r_active[g].cx),
        .cy    (r_active[g].cy),
        .r_in  (r_active[g].r_in),
        .r_out (r_active[g].r_out),
        .hit   (w_hit[g])
      );
    end
  endgenerate

`ifdef RING_CHECKER_EN
  logic [1:0] r_chk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_chk <= '0;
    else        r_chk <= {r_chk[0], x[4] ^ y[4]};
  end

  assign w_nohit = r_chk[1] ? ~bg_color : bg_color;
`else
  assign w_nohit = bg_color;
`endif

  // Walk from the highest index down so the lowest hitting ring wins.
  always_comb begin
    w_pix = w_nohit;
    for (int k = NUM_RINGS - 1; k >= 0; k--) begin
      if (w_hit[k]) w_pix = r_active[k].color;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tim_s1 <= '0;
      r_tim_s2 <= '0;
      rgb      <= '0;
      video_on <= 1'b0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
    end else begin
      r_tim_s1                  <= {video_on_in, hsync_in, vsync_in};
      r_tim_s2                  <= r_tim_s1;
      {video_on, hsync, vsync}  <= r_tim_s2;
      rgb                       <= r_tim_s2[2] ? w_pix : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ring_renderer : directed stimulus with a latency-tagged scoreboard       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ring_renderer;
  import ring_pkg::*;

  localparam int N  = 3;
  localparam int CW = 10;
  localparam int KW = 12;
  localparam int SW = sel_width(N);

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] x, y;
  logic          video_on_in, hsync_in, vsync_in;
  logic [KW-1:0] bg_color;
  logic          cfg_we;
  logic [SW-1:0] cfg_sel;
  logic [CW-1:0] cfg_cx, cfg_cy, cfg_r_in, cfg_r_out;
  logic [KW-1:0] cfg_color;
  logic [KW-1:0] rgb;
  logic          hsync, vsync, video_on;

  always #5 clk = ~clk;

  ring_renderer #(.NUM_RINGS(N), .COORD_W(CW), .COLOR_W(KW)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .bg_color(bg_color), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_r_in(cfg_r_in), .cfg_r_out(cfg_r_out),
    .cfg_color(cfg_color), .rgb(rgb), .hsync(hsync), .vsync(vsync), .video_on(video_on)
  );

  typedef struct { int cx; int cy; int rin; int rout; int col; } mcfg_t;
  typedef struct { logic [KW-1:0] rgb; logic [2:0] tim; int due; string tag; } exp_t;

  mcfg_t m_stage [N];
  mcfg_t m_active[N];
  exp_t  q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  bit    mon_en = 0;
  bit    m_prev_vs = 0;
  bit    m_copy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] model_pix(input int px, input int py, input bit von);
    int dx, dy, d2;
    if (!von) return '0;
    for (int k = 0; k < N; k++) begin
      dx = px - m_active[k].cx;
      dy = py - m_active[k].cy;
      d2 = dx * dx + dy * dy;
      if (m_active[k].rout > m_active[k].rin &&
          d2 >= m_active[k].rin * m_active[k].rin &&
          d2 <  m_active[k].rout * m_active[k].rout)
        return KW'(m_active[k].col);
    end
`ifdef RING_CHECKER_EN
    if ((((px >> 4) ^ (py >> 4)) & 1) != 0) return ~bg_color;
`endif
    return bg_color;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_stage[k]  = '{0, 0, 0, 0, 0};
      m_active[k] = '{0, 0, 0, 0, 0};
    end
    m_prev_vs = 0;
    m_copy    = 0;
  endtask

  task automatic drive(input int px, input int py, input bit von, input bit hs, input bit vs,
                       input string tag, input bit we, input int sel, input int cx, input int cy,
                       input int rin, input int rout, input int col);
    exp_t e;
    @(negedge clk);
    x = CW'(px); y = CW'(py);
    video_on_in = von; hsync_in = hs; vsync_in = vs;
    cfg_we = we; cfg_sel = SW'(sel);
    cfg_cx = CW'(cx); cfg_cy = CW'(cy); cfg_r_in = CW'(rin); cfg_r_out = CW'(rout);
    cfg_color = KW'(col);
    if (m_copy) m_active = m_stage;
    if (we && sel < N) m_stage[sel] = '{cx, cy, rin, rout, col};
    m_copy    = vs && !m_prev_vs;
    m_prev_vs = vs;
    e.rgb = model_pix(px, py, von);
    e.tim = {von, hs, vs};
    e.due = cyc + PIPE_LAT;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic pix(input int px, input int py, input string tag);
    drive(px, py, 1, 0, 0, tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, "idle", 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int sel, input int cx, input int cy, input int rin, input int rout,
                    input int col);
    drive(0, 0, 0, 1, 0, "wr", 1, sel, cx, cy, rin, rout, col);
  endtask

  task automatic vpulse();
    repeat (2) drive(0, 0, 0, 0, 1, "vs", 0, 0, 0, 0, 0, 0, 0);
    idle(4);
  endtask

  // Output monitor: pops every expectation whose due cycle has arrived.
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          if (e.due < cyc) chk({e.tag, "_due"}, cyc, e.due);
          else begin
            chk({e.tag, "_rgb"}, rgb, e.rgb);
            chk({e.tag, "_timing"}, {video_on, hsync, vsync}, e.tim);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    x = 10'd320; y = 10'd130;
    video_on_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    bg_color = 12'h123;
    cfg_we = 1'b0; cfg_sel = '0;
    cfg_cx = '0; cfg_cy = '0; cfg_r_in = '0; cfg_r_out = '0; cfg_color = '0;
    model_clear();

    repeat (4) @(negedge clk);
    chk("rst_rgb", rgb, 0);
    chk("rst_video_on", video_on, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    vsync_in = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Small frame with no rings configured.
    for (int yy = 0; yy < 6; yy++)
      for (int xx = 0; xx < 40; xx++)
        drive(xx, yy, (xx < 32) && (yy < 4), (xx >= 34) && (xx < 37), yy == 5, "frame",
              0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Single ring and its radial boundaries.
    wr(0, 320, 240, 100, 120, 'hF00);
    vpulse();
    pix(320, 130, "r0_hit");
    pix(320, 240, "r0_centre");
    pix(320, 120, "r0_outer_edge");
    pix(320, 140, "r0_inner_edge");
    pix(320, 121, "r0_outer_in");
    idle(3);

    // Overlap priority.
    wr(1, 320, 140, 0, 50, 'h0F0);
    vpulse();
    pix(320, 130, "prio_r0");
    idle(3);
    wr(0, 320, 240, 100, 0, 'hF00);
    vpulse();
    pix(320, 130, "prio_r1");
    idle(3);

    // Write landing in the copy cycle waits for the next frame.
    drive(0, 0, 0, 0, 1, "vs", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, "copy_wr", 1, 1, 320, 140, 0, 50, 'h00F);
    idle(4);
    pix(320, 130, "copy_same");
    idle(3);
    vpulse();
    pix(320, 130, "copy_next");
    idle(3);

    // Out-of-range select is ignored.
    wr(N, 320, 130, 0, 1000, 'hABC);
    vpulse();
    pix(320, 130, "sel_oor_hit");
    pix(5, 5, "sel_oor_bg");
    idle(3);

    // Back-to-back writes keep the last one.
    wr(2, 0, 0, 0, 5, 'hEEE);
    wr(2, 600, 400, 0, 5, 'hDDD);
    vpulse();
    pix(0, 0, "b2b_old");
    pix(600, 400, "b2b_new");
    pix(604, 400, "b2b_edge_in");
    pix(605, 400, "b2b_edge_out");
    idle(3);

    // Degenerate ring with r_out == r_in.
    wr(2, 600, 400, 5, 5, 'hDDD);
    vpulse();
    pix(605, 400, "degen_edge");
    pix(600, 400, "degen_centre");
    idle(3);

    // Background pattern with a black background.
    bg_color = 12'h000;
    idle(3);
    pix(0, 0, "chk_0_0");
    pix(16, 0, "chk_16_0");
    pix(16, 16, "chk_16_16");
    idle(3);

    // Mid-frame reset clears every ring.
    pix(320, 130, "pre_rst");
    pix(321, 130, "pre_rst");
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b0;
    q.delete();
    model_clear();
    bg_color = 12'h123;
    repeat (2) @(negedge clk);
    chk("rst2_rgb", rgb, 0);
    chk("rst2_video_on", video_on, 0);
    chk("rst2_hsync", hsync, 0);
    chk("rst2_vsync", vsync, 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    pix(320, 130, "post_rst");
    pix(600, 400, "post_rst");
    idle(3);
    vpulse();
    pix(320, 130, "post_rst_vs");
    pix(321, 141, "post_rst_vs");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
